// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one full-adder step per enabled clock.
// Operands load in parallel on start; result and flags return in parallel with done.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           s;
  logic           c_next;

  always_comb begin
    s      = reg_a[0] ^ reg_b[0] ^ carry;
    c_next = (reg_a[0] & reg_b[0]) |
             (reg_a[0] & carry) |
             (reg_b[0] & carry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      reg_a  <= '0;
      reg_b  <= '0;
      result <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // subtraction is a + ~b + 1, the +1 entering as initial carry
            reg_a  <= a_in;
            reg_b  <= sub ? ~b_in : b_in;
            carry  <= sub;
            result <= '0;
            cnt    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            state  <= SHIFT;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          if (en) begin
            result <= {s, result[WIDTH-1:1]};
            reg_a  <= reg_a >> 1;
            reg_b  <= reg_b >> 1;
            carry  <= c_next;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              cout  <= c_next;
              ovf   <= carry ^ c_next;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=8 and WIDTH=16.
// Stimulus pushes expected results; per-instance monitors pop on done.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;
  logic start8, sub8;
  logic [7:0] a8, b8, result8;
  logic ready8, busy8, done8, cout8, ovf8;
  logic start16, sub16;
  logic [15:0] a16, b16, result16;
  logic ready16, busy16, done16, cout16, ovf16;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .en(en),
    .a_in(a8), .b_in(b8), .ready(ready8), .busy(busy8),
    .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .en(en),
    .a_in(a16), .b_in(b16), .ready(ready16), .busy(busy16),
    .done(done16), .result(result16), .cout(cout16), .ovf(ovf16)
  );

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        ov;
    int          t0;
    int          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("spurious_done8", 32'(done8), 0);
      end else begin
        e8 = q8.pop_front();
        check("result8", 32'(result8), 32'(e8.res));
        check("cout8", 32'(cout8), 32'(e8.co));
        check("ovf8", 32'(ovf8), 32'(e8.ov));
        check("latency8", cyc - e8.t0, e8.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        check("spurious_done16", 32'(done16), 0);
      end else begin
        e16 = q16.pop_front();
        check("result16", 32'(result16), 32'(e16.res));
        check("cout16", 32'(cout16), 32'(e16.co));
        check("ovf16", 32'(ovf16), 32'(e16.ov));
        check("latency16", cyc - e16.t0, e16.lat);
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] er,
                        input logic eco, input logic eov,
                        input int lat);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    q8.push_back('{16'(er), eco, eov, cyc, lat});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input int maxc);
    int k = 0;
    while (done8 !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (done8 !== 1'b1) begin
      check("timeout8", 32'(done8), 1);
    end else begin
      @(negedge clk);
      check("done_pulse8", 32'(done8), 0);
      check("ready_after8", 32'(ready8), 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready8), 1);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_result", 32'(result8), 0);
    check("rst_cout", 32'(cout8), 0);
    check("rst_ovf", 32'(ovf8), 0);
    rst = 1'b0;

    issue8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 9);
    check("busy_in_shift", 32'(busy8), 1);
    check("ready_in_shift", 32'(ready8), 0);
    wait_done8(40);
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 9);
    wait_done8(40);
    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 9);
    wait_done8(40);
    issue8(8'h05, 8'h06, 1'b1, 8'hFF, 1'b0, 1'b0, 9);
    wait_done8(40);
    issue8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 9);
    wait_done8(40);

    // three stalled edges after two bits have been stepped
    issue8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 12);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("busy_stalled", 32'(busy8), 1);
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_done8(40);

    // start while busy and in the DONE cycle must be ignored
    issue8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 9);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("ready_low_busy", 32'(ready8), 0);
    for (int k = 0; k < 40 && done8 !== 1'b1; k++) @(negedge clk);
    check("done_seen", 32'(done8), 1);
    check("ready_low_done", 32'(ready8), 0);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("ready_idle", 32'(ready8), 1);
    check("result_held", 32'(result8), 32'h41);
    repeat (12) @(negedge clk);
    check("no_restart", 32'(busy8), 0);
    check("result_still", 32'(result8), 32'h41);

    // reset in the middle of an add
    a8 = 8'h3C; b8 = 8'h05; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ready", 32'(ready8), 1);
    check("mrst_busy", 32'(busy8), 0);
    check("mrst_result", 32'(result8), 0);
    check("mrst_cout", 32'(cout8), 0);
    check("mrst_ovf", 32'(ovf8), 0);
    repeat (12) @(negedge clk);
    check("mrst_idle", 32'(ready8), 1);

    // 16-bit instance
    @(negedge clk);
    a16 = 16'h8000; b16 = 16'h0001; sub16 = 1'b1; start16 = 1'b1;
    q16.push_back('{16'h7FFF, 1'b1, 1'b1, cyc, 17});
    @(negedge clk);
    start16 = 1'b0;
    for (int k = 0; k < 60 && done16 !== 1'b1; k++) @(negedge clk);
    check("done16_seen", 32'(done16), 1);
    @(negedge clk);
    check("done16_pulse", 32'(done16), 0);
    check("ready16_after", 32'(ready16), 1);

    repeat (4) @(negedge clk);
    check("q8_empty", q8.size(), 0);
    check("q16_empty", q16.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
